// File: rtl/tia_pkg.sv
// Shared definitions for the TIA counter / delay-chain blocks.
//   TIA_MODE_DELAY / TIA_MODE_POLY : values of the tia_delay_chain mode input
//   TIA_HC_FB_MASK / TIA_HC_WRAP   : horizontal-counter feedback taps and wrap value
//   tia_word_t                     : 6-bit counter word
package tia_pkg;

  typedef logic [5:0] tia_word_t;

  localparam logic TIA_MODE_DELAY = 1'b0;
  localparam logic TIA_MODE_POLY  = 1'b1;

  localparam tia_word_t TIA_HC_FB_MASK = 6'b000011;
  localparam tia_word_t TIA_HC_WRAP    = 6'b000000;

endpackage

// File: rtl/tia_poly_fb.sv
// Combinational helper for the polynomial-counter mode of tia_delay_chain.
// Ports:
//   q         in  DEPTH  current chain contents
//   match_val in  DEPTH  decode value
//   fb        out 1      XNOR of the masked chain bits (next bit shifted into q[0])
//   all_ones  out 1      chain is in the XNOR lockup state
//   hit       out 1      chain equals match_val
module tia_poly_fb
  import tia_pkg::*;
#(
  parameter int              DEPTH   = 6,
  parameter logic [DEPTH-1:0] FB_MASK = DEPTH'(TIA_HC_FB_MASK)
) (
  input  logic [DEPTH-1:0] q,
  input  logic [DEPTH-1:0] match_val,
  output logic             fb,
  output logic             all_ones,
  output logic             hit
);

  assign fb       = ~^(q & FB_MASK);
  assign all_ones = &q;
  assign hit      = (q == match_val);

endmodule

// File: rtl/tia_delay_chain.sv
// DEPTH-stage shift chain with true/complement output of a selectable stage.
// Runs as a plain delay line or, when TIA_DELAY_CHAIN_POLY_EN is defined, as an
// XNOR polynomial counter with decode-and-wrap and lockup recovery.
// Without TIA_DELAY_CHAIN_POLY_EN the block is always a delay line, mode and
// match_val are ignored and match/lock are tied low.
// Ports:
//   clk       in  1              system clock, all state changes on posedge
//   rsyn      in  1              synchronous active-high reset
//   adv       in  1              advance enable, one chain step per cycle
//   din       in  1              serial input (delay mode)
//   mode      in  1              0 = delay line, 1 = polynomial counter
//   sel       in  $clog2(DEPTH)  stage driven onto out/tap
//   match_val in  DEPTH          poly decode value
//   q         out DEPTH          registered chain, q[0] newest bit
//   out       out 1              q[sel], 0 when sel >= DEPTH
//   tap       out 1              ~out
//   match     out 1              one-cycle wrap pulse
//   lock      out 1              one-cycle lockup-recovery pulse
module tia_delay_chain
  import tia_pkg::*;
#(
  parameter int               DEPTH     = 6,
  parameter logic [DEPTH-1:0] FB_MASK   = DEPTH'(TIA_HC_FB_MASK),
  parameter logic [DEPTH-1:0] RESET_VAL = DEPTH'(TIA_HC_WRAP)
) (
  input  logic                     clk,
  input  logic                     rsyn,
  input  logic                     adv,
  input  logic                     din,
  input  logic                     mode,
  input  logic [$clog2(DEPTH)-1:0] sel,
  input  logic [DEPTH-1:0]         match_val,
  output logic [DEPTH-1:0]         q,
  output logic                     out,
  output logic                     tap,
  output logic                     match,
  output logic                     lock
);

  localparam int SEL_W = $clog2(DEPTH);
  localparam logic [SEL_W:0] DEPTH_CMP = DEPTH[SEL_W:0];

  logic [DEPTH-1:0] q_nxt;
  logic             match_nxt;
  logic             lock_nxt;

`ifdef TIA_DELAY_CHAIN_POLY_EN
  logic fb;
  logic all_ones;
  logic hit;

  tia_poly_fb #(
    .DEPTH   (DEPTH),
    .FB_MASK (FB_MASK)
  ) u_poly_fb (
    .q         (q),
    .match_val (match_val),
    .fb        (fb),
    .all_ones  (all_ones),
    .hit       (hit)
  );

  // Wrap on decode takes priority over lockup recovery, which takes priority
  // over the normal XNOR step.
  always_comb begin
    q_nxt     = q;
    match_nxt = 1'b0;
    lock_nxt  = 1'b0;
    if (adv) begin
      if (mode == TIA_MODE_POLY) begin
        if (hit) begin
          q_nxt     = RESET_VAL;
          match_nxt = 1'b1;
        end else if (all_ones) begin
          q_nxt    = RESET_VAL;
          lock_nxt = 1'b1;
        end else begin
          q_nxt = {q[DEPTH-2:0], fb};
        end
      end else begin
        q_nxt = {q[DEPTH-2:0], din};
      end
    end
  end
`else
  // Delay-line only build: mode and match_val have no effect.
  logic unused_cfg;
  assign unused_cfg = ^{mode, match_val};

  always_comb begin
    q_nxt     = q;
    match_nxt = 1'b0;
    lock_nxt  = 1'b0;
    if (adv) begin
      q_nxt = {q[DEPTH-2:0], din};
    end
  end
`endif

  // Chain register and pulse flags; a reset edge also swallows any pending pulse.
  always_ff @(posedge clk) begin
    if (rsyn) begin
      q     <= RESET_VAL;
      match <= 1'b0;
      lock  <= 1'b0;
    end else begin
      q     <= q_nxt;
      match <= match_nxt;
      lock  <= lock_nxt;
    end
  end

  // Out-of-range selects read as 0 rather than an undefined stage.
  assign out = ({1'b0, sel} < DEPTH_CMP) ? q[sel] : 1'b0;
  assign tap = ~out;

endmodule

// File: tb/tb_tia_delay_chain.sv
module tb_tia_delay_chain;

  logic       clk = 1'b0;
  logic       rsyn;
  logic       adv;
  logic       din;
  logic       mode;
  logic [2:0] sel;
  logic [5:0] match_val;
  logic [5:0] q;
  logic       out;
  logic       tap;
  logic       match;
  logic       lock;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tia_delay_chain #(
    .DEPTH     (6),
    .FB_MASK   (6'b000011),
    .RESET_VAL (6'b000000)
  ) dut (
    .clk       (clk),
    .rsyn      (rsyn),
    .adv       (adv),
    .din       (din),
    .mode      (mode),
    .sel       (sel),
    .match_val (match_val),
    .q         (q),
    .out       (out),
    .tap       (tap),
    .match     (match),
    .lock      (lock)
  );

  // Reference model: chain value as a number 0..63, flags as bits.
  logic [5:0] mq;
  logic       mm;
  logic       ml;

  task automatic model_step();
    int v;
    mm = 1'b0;
    ml = 1'b0;
    if (rsyn) begin
      mq = 6'd0;
    end else if (adv) begin
`ifdef TIA_DELAY_CHAIN_POLY_EN
      if (mode) begin
        if (mq == match_val) begin
          mq = 6'd0;
          mm = 1'b1;
        end else if (mq == 6'd63) begin
          mq = 6'd0;
          ml = 1'b1;
        end else begin
          // New bit is 1 when the tapped bits hold an even number of ones.
          v  = int'(mq) * 2 + (($countones(mq & 6'b000011) % 2 == 0) ? 1 : 0);
          mq = 6'(v % 64);
        end
      end else begin
        v  = int'(mq) * 2 + int'(din);
        mq = 6'(v % 64);
      end
`else
      v  = int'(mq) * 2 + int'(din);
      mq = 6'(v % 64);
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cmp(input string name, input logic [5:0] eq, input logic em, input logic el);
    logic eo;
    int   idx;
    idx = int'(sel);
    eo  = (idx < 6) ? eq[idx] : 1'b0;
    vectors++;
    if (q !== eq || out !== eo || tap !== ~eo || match !== em || lock !== el) begin
      miscompares++;
      $display("FAIL %s: got q=%b out=%b tap=%b match=%b lock=%b, want q=%b out=%b tap=%b match=%b lock=%b",
               name, q, out, tap, match, lock, eq, eo, ~eo, em, el);
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic d, input logic m,
                       input logic [2:0] s, input logic [5:0] mv);
    rsyn = r; adv = a; din = d; mode = m; sel = s; match_val = mv;
  endtask

  typedef struct {
    logic       r, a, d, m;
    logic [2:0] s;
    logic [5:0] mv;
    logic [5:0] eq;
    logic       em, el;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Delay line: a single 1 walks up the chain, sel=2 sees it after the 3rd advance.
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 6'd0, 6'b000001, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 6'd0, 6'b000010, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 6'd0, 6'b000100, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 6'd0, 6'b001000, 1'b0, 1'b0});
    // Hold for 5 cycles, including a mode change while idle.
    for (int i = 0; i < 5; i++)
      tbl.push_back('{1'b0, 1'b0, 1'b1, 1'(i % 2), 3'd3, 6'b001000, 6'b001000, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 6'd0, 6'b000000, 1'b0, 1'b0});
`ifdef TIA_DELAY_CHAIN_POLY_EN
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 6'b111110, 6'b000001, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 6'b111110, 6'b000010, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 6'b000100, 6'b000100, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 6'b000100, 6'b000000, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 6'b000100, 6'b000000, 1'b0, 1'b0});
`else
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 6'b000000, 6'b000001, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 6'b000001, 6'b000011, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 6'b000011, 6'b000110, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 6'b000110, 6'b001100, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 6'b001100, 6'b001100, 1'b0, 1'b0});
`endif

    mq = 6'd0; mm = 1'b0; ml = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 6'd0);
    tick();
    cmp("reset", 6'd0, 1'b0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].m, tbl[i].s, tbl[i].mv);
      tick();
      cmp($sformatf("table[%0d]", i), tbl[i].eq, tbl[i].em, tbl[i].el);
    end

    // Lockup: fill with ones in delay mode, then one advance in poly mode.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 6'd0);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 6'd0);
      tick();
    end
    cmp("lock_fill", 6'b111111, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 6'b010101);
    tick();
`ifdef TIA_DELAY_CHAIN_POLY_EN
    cmp("lockup", 6'b000000, 1'b0, 1'b1);
`else
    cmp("lockup", 6'b111111, 1'b0, 1'b0);
`endif
    drive(1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 6'b010101);
    tick();
    cmp("lock_pulse_end", mq, 1'b0, 1'b0);

    // Out-of-range select on an all-ones chain.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 6'd0);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd6, 6'd0);
      tick();
    end
    cmp("sel6", 6'b111111, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 6'd0);
    tick();
    cmp("sel7", 6'b111111, 1'b0, 1'b0);

    // Reset dominates an advance on q=101010.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 6'd0);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'((i + 1) % 2), 1'b0, 3'd1, 6'd0);
      tick();
    end
    cmp("fill_101010", 6'b101010, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 6'b101010);
    tick();
    cmp("reset_dominates", 6'd0, 1'b0, 1'b0);

`ifdef TIA_DELAY_CHAIN_POLY_EN
    // A reset on the edge that would wrap suppresses the match pulse.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 6'b000100);
      tick();
    end
    cmp("pre_wrap", 6'b000100, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 6'b000100);
    tick();
    cmp("reset_kills_match", 6'd0, 1'b0, 1'b0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic [5:0] mv;
      case ($urandom_range(0, 3))
        0:       mv = 6'b000100;
        1:       mv = 6'b001001;
        2:       mv = 6'b111111;
        default: mv = 6'($urandom);
      endcase
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
            ($urandom_range(0, 2) != 0), 3'($urandom), mv);
      tick();
      cmp($sformatf("random[%0d]", i), mq, mm, ml);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
